snn_spike_tally: RTL and testbench
==================================

Name: snn_spike_tally

Overview:
- Parametrised output-layer spike tally and classifier readout; sits between snn_computation_core output spikes and the host register interface in the FPGA top.
- Counts per-class output spikes over one inference run with saturation and snapshots the counts into a host-readable result bank.
- Finds the winning class by sequential argmax and raises a sticky interrupt.
- Adds over the previous generation: any class count, configurable counter width, run counter, winner register, soft start over the host bus, and done/irq handshake.

Parameters:
- NUM_CLASSES, 10, number of output neurons/classes (2..64)
- CNT_W, 16, per-class spike counter width (saturating)
- IDX_W, $clog2(NUM_CLASSES), width of winner index
- ADDR_W, 8, host byte-address width (register map must fit)
- DATA_W, 32, host data width (>= CNT_W and >= IDX_W+CNT_W)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- start  in  1  single-cycle pulse; begins a run
- out_spikes  in  NUM_CLASSES  per-class spike bits from the core, sampled each clk
- core_done  in  1  single-cycle pulse from the core; ends the run
- host_addr  in  ADDR_W  byte address, word-aligned
- host_wdata  in  DATA_W  host write data
- host_wr_en  in  1  host write strobe
- host_rd_en  in  1  host read strobe
- host_rdata  out  DATA_W  read data
- host_rvalid  out  1  read data valid
- busy  out  1  high from the accepted start until result_valid
- result_valid  out  1  result bank holds a complete run
- winner_idx  out  IDX_W  argmax class of the last run
- irq  out  1  sticky run-complete interrupt

Behaviour:
- Reset (async, rst=1): all counters, the result bank, winner_idx, run_count, host_rdata, host_rvalid, busy, result_valid and irq are 0. State is IDLE. Reset mid-run aborts the run with no partial result.
- FSM states:
  - IDLE: on start, or a host write to CTRL with bit0=1, clear the live counters, set busy, clear result_valid, go to COUNT.
  - COUNT: each cycle, for every i with out_spikes[i]=1, cnt[i]++, saturating at 2^CNT_W-1. Spikes on the core_done cycle are counted. When core_done arrives, go to SCAN.
  - SCAN: compare one class per cycle, NUM_CLASSES cycles total. Ties resolve to the lowest index. Then go to DONE.
  - DONE: in one cycle, copy cnt into the result bank, update winner_idx/winner_cnt, increment run_count (wraps at 2^32), set result_valid and irq, clear busy, go to IDLE.
- Latency: core_done to result_valid is NUM_CLASSES+1 cycles.
- start or soft-start while busy is ignored. core_done outside COUNT is ignored.
- start and core_done in the same IDLE cycle: start wins and core_done is dropped.
- The result bank is stable while the next run counts; it changes only in DONE.
- irq stays high until a host write to CTRL with bit1=1. If that clear and DONE occur in the same cycle, set wins.
- Host reads:
  - Latency is 1 cycle: host_rvalid pulses 1 cycle after host_rd_en, carrying host_rdata.
  - Unmapped addresses read 0.
  - Writes to read-only registers are ignored.
- Register map (byte offsets), all fields zero-extended:
  - 0x00 STATUS {irq, result_valid, busy} in bits [2:0]
  - 0x04 CTRL write-only: bit0 soft start, bit1 irq clear; reads 0
  - 0x08 WINNER {winner_cnt[CNT_W-1:0] at [31:16] for CNT_W=16, winner_idx at [IDX_W-1:0]}
  - 0x0C RUN_COUNT
  - 0x10 + 4*i RESULT[i], for i < NUM_CLASSES

Decomposition:
- Package snn_tally_pkg holds:
  - register offsets (REG_STATUS, REG_CTRL, REG_WINNER, REG_RUNCNT, REG_RESULT_BASE)
  - CTRL bit positions
  - FSM state encoding
- Sub-module snn_argmax_seq holds the SCAN datapath: index counter, best-value/best-index registers, lowest-index tie rule, done pulse.
- The top level holds the counters, result bank, FSM and host decode.

Test Plan:
- Run where class 3 spikes on 40 cycles and class 7 on 25 cycles, then core_done -> after 11 cycles result_valid=1, winner_idx=3, RESULT[3]=40, RESULT[7]=25, other classes 0, irq=1, RUN_COUNT=1.
- CNT_W=4, class 0 spiking continuously for 30 cycles -> RESULT[0]=15 (saturated), winner_idx=0.
- Classes 2 and 5 both at 12 spikes -> winner_idx=2 (lowest-index tie rule).
- start pulse during COUNT, and core_done while IDLE -> no state change, counts unaffected. Then write CTRL=0x2 -> irq=0 while STATUS.result_valid stays 1.
- Soft start via CTRL=0x1 -> busy=1. Assert rst mid-COUNT -> all outputs 0, STATUS reads 0x0. Read of 0xFC -> host_rdata=0 with host_rvalid one cycle later.
- Two back-to-back runs -> the first run's RESULT values are readable throughout the second run's COUNT, then replaced. RUN_COUNT=2.

Source files
------------

// File: rtl/snn_tally_pkg.sv
// Shared constants for the spike tally block: host register map,
// CTRL bit positions and the run-control state encoding.
package snn_tally_pkg;

    localparam logic [7:0] REG_STATUS      = 8'h00;
    localparam logic [7:0] REG_CTRL        = 8'h04;
    localparam logic [7:0] REG_WINNER      = 8'h08;
    localparam logic [7:0] REG_RUNCNT      = 8'h0C;
    localparam logic [7:0] REG_RESULT_BASE = 8'h10;

    localparam int unsigned CTRL_START_BIT   = 32'd0;
    localparam int unsigned CTRL_IRQ_CLR_BIT = 32'd1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_SCAN  = 2'd2,
        ST_DONE  = 2'd3
    } tally_state_t;

endpackage

// File: rtl/snn_argmax_seq.sv
// Sequential argmax over a flattened vector of class counts.
// One class is examined per enabled cycle; a strict greater-than compare
// keeps the lowest index on ties. done is high during the cycle that
// examines the last class, so best_* are final on the following cycle.
module snn_argmax_seq
    import snn_tally_pkg::*;
#(
    parameter int NUM_CLASSES = 10,
    parameter int CNT_W       = 16,
    parameter int IDX_W       = $clog2(NUM_CLASSES)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    input  logic                         en,
    input  logic [NUM_CLASSES*CNT_W-1:0] values,
    output logic [IDX_W-1:0]             best_idx,
    output logic [CNT_W-1:0]             best_val,
    output logic                         done
);

    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] cur_val;
    logic             last;

    // Select the count currently under examination.
    always_comb begin
        cur_val = '0;
        for (int i = 0; i < NUM_CLASSES; i++) begin
            cur_val = (idx == IDX_W'(i)) ? values[i*CNT_W +: CNT_W] : cur_val;
        end
        last = (idx == IDX_W'(NUM_CLASSES - 1));
        done = en && last;
    end

    // Walk the classes, keeping the first maximum seen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx      <= '0;
            best_idx <= '0;
            best_val <= '0;
        end else if (clear) begin
            idx      <= '0;
            best_idx <= '0;
            best_val <= '0;
        end else if (en) begin
            if (cur_val > best_val) begin
                best_val <= cur_val;
                best_idx <= idx;
            end
            idx <= last ? '0 : idx + IDX_W'(1);
        end
    end

endmodule

// File: rtl/snn_spike_tally.sv
// Output-layer spike tally: saturating per-class counters over one run,
// sequential argmax readout, a snapshot result bank and a host register
// interface with a sticky run-complete interrupt.
module snn_spike_tally
    import snn_tally_pkg::*;
#(
    parameter int NUM_CLASSES = 10,
    parameter int CNT_W       = 16,
    parameter int IDX_W       = $clog2(NUM_CLASSES),
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [NUM_CLASSES-1:0] out_spikes,
    input  logic                   core_done,
    input  logic [ADDR_W-1:0]      host_addr,
    input  logic [DATA_W-1:0]      host_wdata,
    input  logic                   host_wr_en,
    input  logic                   host_rd_en,
    output logic [DATA_W-1:0]      host_rdata,
    output logic                   host_rvalid,
    output logic                   busy,
    output logic                   result_valid,
    output logic [IDX_W-1:0]       winner_idx,
    output logic                   irq
);

    tally_state_t state, state_next;

    logic [CNT_W-1:0]             cnt  [NUM_CLASSES];
    logic [CNT_W-1:0]             bank [NUM_CLASSES];
    logic [NUM_CLASSES*CNT_W-1:0] cnt_flat;
    logic [CNT_W-1:0]             winner_cnt;
    logic [31:0]                  run_count;

    logic ctrl_wr, soft_start, irq_clr, start_req;
    logic run_begin, scan_begin, scan_en, scan_done;
    logic [IDX_W-1:0]  scan_idx;
    logic [CNT_W-1:0]  scan_val;
    logic [DATA_W-1:0] rd_mux;
    logic              unused_wdata;

    // Host control decode and run-start / scan-start qualification.
    always_comb begin
        ctrl_wr    = host_wr_en && (host_addr == ADDR_W'(REG_CTRL));
        soft_start = ctrl_wr && host_wdata[CTRL_START_BIT];
        irq_clr    = ctrl_wr && host_wdata[CTRL_IRQ_CLR_BIT];
        start_req  = start || soft_start;
        run_begin  = (state == ST_IDLE) && start_req;
        scan_begin = (state == ST_COUNT) && core_done;
        scan_en    = (state == ST_SCAN);
        unused_wdata = &{1'b0, host_wdata};
    end

    // Run-control state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Run-control next state; start beats a coincident core_done in IDLE.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (start_req) state_next = ST_COUNT; else state_next = ST_IDLE;
            ST_COUNT: if (core_done) state_next = ST_SCAN;  else state_next = ST_COUNT;
            ST_SCAN:  if (scan_done) state_next = ST_DONE;  else state_next = ST_SCAN;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Live saturating spike counters, cleared when a run begins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CLASSES; i++) cnt[i] <= '0;
        end else if (run_begin) begin
            for (int i = 0; i < NUM_CLASSES; i++) cnt[i] <= '0;
        end else if (state == ST_COUNT) begin
            for (int i = 0; i < NUM_CLASSES; i++) begin
                if (out_spikes[i] && (cnt[i] != {CNT_W{1'b1}})) begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Flatten the live counters for the argmax datapath.
    always_comb begin
        cnt_flat = '0;
        for (int i = 0; i < NUM_CLASSES; i++) cnt_flat[i*CNT_W +: CNT_W] = cnt[i];
    end

    snn_argmax_seq #(
        .NUM_CLASSES (NUM_CLASSES),
        .CNT_W       (CNT_W),
        .IDX_W       (IDX_W)
    ) u_argmax (
        .clk      (clk),
        .rst      (rst),
        .clear    (scan_begin),
        .en       (scan_en),
        .values   (cnt_flat),
        .best_idx (scan_idx),
        .best_val (scan_val),
        .done     (scan_done)
    );

    // Result bank: only replaced when a run completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CLASSES; i++) bank[i] <= '0;
        end else if (state == ST_DONE) begin
            for (int i = 0; i < NUM_CLASSES; i++) bank[i] <= cnt[i];
        end
    end

    // Run status, winner, run counter and sticky irq (set beats clear).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy         <= 1'b0;
            result_valid <= 1'b0;
            winner_idx   <= '0;
            winner_cnt   <= '0;
            run_count    <= 32'd0;
            irq          <= 1'b0;
        end else begin
            if (run_begin) begin
                busy         <= 1'b1;
                result_valid <= 1'b0;
            end else if (state == ST_DONE) begin
                busy         <= 1'b0;
                result_valid <= 1'b1;
                winner_idx   <= scan_idx;
                winner_cnt   <= scan_val;
                run_count    <= run_count + 32'd1;
            end
            if (state == ST_DONE) begin
                irq <= 1'b1;
            end else if (irq_clr) begin
                irq <= 1'b0;
            end
        end
    end

    // Host read decode; unmapped and write-only addresses return zero.
    always_comb begin
        rd_mux = '0;
        if (host_addr == ADDR_W'(REG_STATUS)) begin
            rd_mux = DATA_W'({irq, result_valid, busy});
        end else if (host_addr == ADDR_W'(REG_WINNER)) begin
            rd_mux[DATA_W-1 -: CNT_W] = winner_cnt;
            rd_mux[IDX_W-1:0]         = winner_idx;
        end else if (host_addr == ADDR_W'(REG_RUNCNT)) begin
            rd_mux = DATA_W'(run_count);
        end else begin
            for (int i = 0; i < NUM_CLASSES; i++) begin
                rd_mux = (host_addr == ADDR_W'(int'(REG_RESULT_BASE) + 4 * i))
                         ? DATA_W'(bank[i]) : rd_mux;
            end
        end
    end

    // One-cycle registered host read response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            host_rdata  <= '0;
            host_rvalid <= 1'b0;
        end else begin
            host_rvalid <= host_rd_en;
            if (host_rd_en) begin
                host_rdata <= rd_mux;
            end
        end
    end

endmodule

// File: tb/tb_snn_spike_tally.sv
// Directed bench for snn_spike_tally: a table of register reads after a
// known run, plus hand-written sequences for latency, ties, saturation,
// ignored pulses, irq clear, back-to-back runs and mid-run reset.
module tb_snn_spike_tally;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Main instance: 10 classes, 16-bit counters.
    logic        start, core_done, wr_en, rd_en, rvalid, busy, rv, irq;
    logic [9:0]  spikes;
    logic [7:0]  addr;
    logic [31:0] wdata, rdata;
    logic [3:0]  widx;

    // Saturation instance: 10 classes, 4-bit counters.
    logic        b_start, b_core_done, b_wr_en, b_rd_en, b_rvalid, b_busy, b_rv, b_irq;
    logic [9:0]  b_spikes;
    logic [7:0]  b_addr;
    logic [31:0] b_wdata, b_rdata;
    logic [3:0]  b_widx;

    snn_spike_tally #(.NUM_CLASSES(10), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .out_spikes(spikes), .core_done(core_done),
        .host_addr(addr), .host_wdata(wdata), .host_wr_en(wr_en), .host_rd_en(rd_en),
        .host_rdata(rdata), .host_rvalid(rvalid), .busy(busy), .result_valid(rv),
        .winner_idx(widx), .irq(irq)
    );

    snn_spike_tally #(.NUM_CLASSES(10), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .start(b_start), .out_spikes(b_spikes), .core_done(b_core_done),
        .host_addr(b_addr), .host_wdata(b_wdata), .host_wr_en(b_wr_en), .host_rd_en(b_rd_en),
        .host_rdata(b_rdata), .host_rvalid(b_rvalid), .busy(b_busy), .result_valid(b_rv),
        .winner_idx(b_widx), .irq(b_irq)
    );

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] exp;
    } rd_vec_t;

    rd_vec_t     tbl [16];
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] d;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic rd(input logic [7:0] a, output logic [31:0] data);
        addr  = a;
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        addr  = 8'h00;
        check("rvalid", 32'(rvalid), 32'd1);
        data = rdata;
    endtask

    task automatic rd_chk(input string name, input logic [7:0] a, input logic [31:0] exp);
        logic [31:0] v;
        rd(a, v);
        check(name, v, exp);
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] data);
        addr  = a;
        wdata = data;
        wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
        wdata = 32'd0;
        addr  = 8'h00;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        start = 1'b0; core_done = 1'b0; spikes = 10'd0; addr = 8'h00;
        wdata = 32'd0; wr_en = 1'b0; rd_en = 1'b0;
        b_start = 1'b0; b_core_done = 1'b0; b_spikes = 10'd0; b_addr = 8'h00;
        b_wdata = 32'd0; b_wr_en = 1'b0; b_rd_en = 1'b0;

        // Register image after run 1 (class 3 x40, class 7 x25).
        tbl[0]  = '{8'h00, 32'h0000_0006};
        tbl[1]  = '{8'h04, 32'h0000_0000};
        tbl[2]  = '{8'h08, 32'h0028_0003};
        tbl[3]  = '{8'h0C, 32'h0000_0001};
        for (int i = 0; i < 10; i++) begin
            tbl[4 + i].addr = 8'h10 + 8'(4 * i);
            tbl[4 + i].exp  = (i == 3) ? 32'd40 : ((i == 7) ? 32'd25 : 32'd0);
        end
        tbl[14] = '{8'h38, 32'h0000_0000};
        tbl[15] = '{8'hFC, 32'h0000_0000};

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_result_valid", 32'(rv), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_winner", 32'(widx), 32'd0);
        rst = 1'b0;
        tick();
        rd_chk("rst_status", 8'h00, 32'd0);

        // Run 1 with exact core_done -> result_valid latency.
        start = 1'b1; tick(); start = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
        for (int i = 0; i < 40; i++) begin
            spikes    = 10'd0;
            spikes[3] = 1'b1;
            spikes[7] = (i < 25);
            core_done = (i == 39);
            tick();
        end
        spikes = 10'd0; core_done = 1'b0;
        repeat (10) tick();
        check("rv_not_early", 32'(rv), 32'd0);
        tick();
        check("rv_latency", 32'(rv), 32'd1);
        check("run1_winner", 32'(widx), 32'd3);
        check("run1_irq", 32'(irq), 32'd1);
        check("run1_busy", 32'(busy), 32'd0);

        for (int i = 0; i < 16; i++) begin
            rd(tbl[i].addr, d);
            check($sformatf("reg_0x%02h", tbl[i].addr), d, tbl[i].exp);
        end
        tick();
        check("rvalid_single_pulse", 32'(rvalid), 32'd0);

        // core_done while IDLE is ignored.
        core_done = 1'b1; tick(); core_done = 1'b0;
        check("idle_done_busy", 32'(busy), 32'd0);
        rd_chk("idle_done_status", 8'h00, 32'd6);
        rd_chk("idle_done_result3", 8'h1C, 32'd40);

        // irq clear leaves result_valid; read-only write ignored.
        wr(8'h04, 32'h2);
        check("irq_cleared", 32'(irq), 32'd0);
        rd_chk("status_after_clr", 8'h00, 32'd2);
        wr(8'h0C, 32'h1234);
        rd_chk("runcnt_ro", 8'h0C, 32'd1);

        // Run 2 via soft start: tie between classes 2 and 5, ignored start,
        // previous bank visible during COUNT.
        wr(8'h04, 32'h1);
        check("soft_start_busy", 32'(busy), 32'd1);
        check("soft_start_rv_clr", 32'(rv), 32'd0);
        for (int i = 0; i < 6; i++) begin
            spikes = 10'h024; tick();
        end
        spikes = 10'd0;
        start = 1'b1; tick(); start = 1'b0;
        check("start_in_count_busy", 32'(busy), 32'd1);
        rd_chk("bank_hold_r3", 8'h1C, 32'd40);
        rd_chk("bank_hold_r7", 8'h2C, 32'd25);
        for (int i = 0; i < 6; i++) begin
            spikes = 10'h024; core_done = (i == 5); tick();
        end
        spikes = 10'd0; core_done = 1'b0;
        begin
            int k;
            k = 0;
            while (!rv && k < 20) begin
                tick();
                k++;
            end
        end
        check("run2_done_in_budget", 32'(rv), 32'd1);
        check("tie_winner", 32'(widx), 32'd2);
        rd_chk("run2_r2", 8'h18, 32'd12);
        rd_chk("run2_r5", 8'h24, 32'd12);
        rd_chk("run2_r3", 8'h1C, 32'd0);
        rd_chk("run2_runcnt", 8'h0C, 32'd2);
        rd_chk("run2_winner_reg", 8'h08, 32'h000C_0002);
        check("run2_irq", 32'(irq), 32'd1);

        // Saturating instance: start with coincident core_done, then 30 spikes.
        b_start = 1'b1; b_core_done = 1'b1; tick(); b_start = 1'b0; b_core_done = 1'b0;
        check("sat_start_wins", 32'(b_busy), 32'd1);
        for (int i = 0; i < 30; i++) begin
            b_spikes = 10'h001; b_core_done = (i == 29); tick();
        end
        b_spikes = 10'd0; b_core_done = 1'b0;
        begin
            int k;
            k = 0;
            while (!b_rv && k < 20) begin
                tick();
                k++;
            end
        end
        check("sat_done_in_budget", 32'(b_rv), 32'd1);
        check("sat_winner", 32'(b_widx), 32'd0);
        b_addr = 8'h10; b_rd_en = 1'b1; tick(); b_rd_en = 1'b0;
        check("sat_rvalid", 32'(b_rvalid), 32'd1);
        check("sat_result0", b_rdata, 32'd15);

        // Reset in the middle of a counting run.
        wr(8'h04, 32'h1);
        for (int i = 0; i < 5; i++) begin
            spikes = 10'h008; tick();
        end
        rd(8'h0C, d);
        #2 rst = 1'b1;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_rv", 32'(rv), 32'd0);
        check("midrst_irq", 32'(irq), 32'd0);
        check("midrst_winner", 32'(widx), 32'd0);
        check("midrst_rdata", rdata, 32'd0);
        check("midrst_rvalid", 32'(rvalid), 32'd0);
        rst = 1'b0; spikes = 10'd0;
        tick();
        rd_chk("midrst_status", 8'h00, 32'd0);
        rd_chk("midrst_runcnt", 8'h0C, 32'd0);
        rd_chk("midrst_result3", 8'h1C, 32'd0);
        rd_chk("midrst_winner_reg", 8'h08, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
